// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the llama register file: default geometry,
// address-width helper and the register address/data typedefs.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_NREGS  = 32;

   function automatic int addr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_AW = addr_width(DEF_NREGS);

   typedef logic [DEF_AW-1:0]     reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

   localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write ports,
// claim port and the scoreboard debug vector.
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   parameter int NRD    = 2,
   parameter int NWR    = 2
) ();

   localparam int AW = addr_width(NREGS);

   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_busy;
   logic [NWR-1:0]        wr_en;
   logic [NWR*AW-1:0]     wr_addr;
   logic [NWR*DATA_W-1:0] wr_data;
   logic                  claim_en;
   logic [AW-1:0]         claim_addr;
   logic [NREGS-1:0]      busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by claims, cleared by
// writes, with a same-cycle claim taking precedence over the clearing write.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = DEF_NREGS,
   parameter int NWR      = 2,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = addr_width(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic              claim_en,
   input  logic [AW-1:0]     claim_addr,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy,
   output logic [NREGS-1:0]  busy_vec
);

   logic [NREGS-1:0] busy_reg;
   logic [NREGS-1:0] busy_next;

   always_comb begin
      busy_next = busy_reg;
      for (int w = 0; w < NWR; w++) begin
         if (wr_en[w]) begin
            busy_next[wr_addr[w*AW +: AW]] = 1'b0;
         end
      end
      // Claim applied last so it survives a same-cycle write to the same register.
      if (claim_en) begin
         busy_next[claim_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   assign busy_vec = busy_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd_busy
         logic [AW-1:0] addr;
         logic          wr_hit;

         assign addr = rd_addr[gi*AW +: AW];

         always_comb begin
            wr_hit = 1'b0;
            for (int w = 0; w < NWR; w++) begin
               if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                  wr_hit = 1'b1;
               end
            end
         end

         assign rd_busy[gi] = busy_reg[addr] & ~wr_hit;
      end
   endgenerate

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, optional hard-wired zero
// register and an integrated pending-write scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NREGS    = DEF_NREGS,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = addr_width(NREGS)
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile_sb_if.slave bus
);

   logic [AW-1:0]     rd_addr_a [NRD];
   logic [AW-1:0]     wr_addr_a [NWR];
   logic [DATA_W-1:0] wr_data_a [NWR];
   logic [DATA_W-1:0] mem_q     [NREGS];

   genvar gi;
   generate
      for (gi = 0; gi < NWR; gi++) begin : g_wr_unpack
         assign wr_addr_a[gi] = bus.wr_addr[gi*AW +: AW];
         assign wr_data_a[gi] = bus.wr_data[gi*DATA_W +: DATA_W];
      end

      for (gi = 0; gi < NRD; gi++) begin : g_rd_unpack
         assign rd_addr_a[gi] = bus.rd_addr[gi*AW +: AW];
      end

      // Storage: one register per entry, the higher-indexed write port wins.
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign mem_q[gi] = '0;
         end else begin : g_store
            logic [DATA_W-1:0] q_reg;
            logic              we_hit;
            logic [DATA_W-1:0] wd_sel;

            always_comb begin
               we_hit = 1'b0;
               wd_sel = '0;
               for (int w = 0; w < NWR; w++) begin
                  if (bus.wr_en[w] && (wr_addr_a[w] == AW'(gi))) begin
                     we_hit = 1'b1;
                     wd_sel = wr_data_a[w];
                  end
               end
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  q_reg <= '0;
               end else if (we_hit) begin
                  q_reg <= wd_sel;
               end
            end

            assign mem_q[gi] = q_reg;
         end
      end

      // Bypass is suppressed during reset so every port reads 0 while rst_n is low.
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [DATA_W-1:0] rd_next;

         always_comb begin
            rd_next = mem_q[rd_addr_a[gi]];
            for (int w = 0; w < NWR; w++) begin
               if (rst_n && bus.wr_en[w] && (wr_addr_a[w] == rd_addr_a[gi])) begin
                  rd_next = wr_data_a[w];
               end
            end
            if ((ZERO_REG != 0) && (rd_addr_a[gi] == '0)) begin
               rd_next = '0;
            end
         end

         assign bus.rd_data[gi*DATA_W +: DATA_W] = rd_next;
      end
   endgenerate

   regfile_scoreboard #(
      .NREGS   (NREGS),
      .NWR     (NWR),
      .NRD     (NRD),
      .ZERO_REG(ZERO_REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .claim_en  (bus.claim_en),
      .claim_addr(bus.claim_addr),
      .rd_addr   (bus.rd_addr),
      .rd_busy   (bus.rd_busy),
      .busy_vec  (bus.busy_vec)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized bench for regfile_sb against an array-based reference
// model of the register file and its scoreboard.
module tb_regfile_sb;
   import regfile_pkg::*;

   localparam int DATA_W = 32;
   localparam int NREGS  = 32;
   localparam int NRD    = 2;
   localparam int NWR    = 2;
   localparam int AW     = 5;

   logic clk;
   logic rst_n;

   regfile_sb_if #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

   regfile_sb #(
      .DATA_W  (DATA_W),
      .NREGS   (NREGS),
      .NRD     (NRD),
      .NWR     (NWR),
      .ZERO_REG(1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   reg_addr_t      ra [NRD];
   reg_addr_t      wa [NWR];
   reg_data_t      wd [NWR];
   logic [NWR-1:0] we;
   logic           ce;
   reg_addr_t      ca;

   reg_data_t m_mem  [NREGS];
   bit        m_busy [NREGS];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      for (int k = 0; k < NRD; k++) bus.rd_addr[k*AW +: AW] = ra[k];
      for (int w = 0; w < NWR; w++) begin
         bus.wr_addr[w*AW +: AW]         = wa[w];
         bus.wr_data[w*DATA_W +: DATA_W] = wd[w];
      end
      bus.wr_en      = we;
      bus.claim_en   = ce;
      bus.claim_addr = ca;
   endtask

   task automatic idle();
      we = '0;
      ce = 1'b0;
      ca = '0;
      for (int w = 0; w < NWR; w++) begin
         wa[w] = '0;
         wd[w] = '0;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NREGS; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic reg_data_t exp_rd(input reg_addr_t a);
      if (!rst_n || a == ZERO_ADDR) return '0;
      for (int w = NWR - 1; w >= 0; w--) begin
         if (we[w] && wa[w] == a) return wd[w];
      end
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input reg_addr_t a);
      if (!rst_n) return 1'b0;
      for (int w = 0; w < NWR; w++) begin
         if (we[w] && wa[w] == a) return 1'b0;
      end
      return m_busy[a];
   endfunction

   function automatic logic [NREGS-1:0] exp_busy_vec();
      logic [NREGS-1:0] v;
      for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_update();
      if (!rst_n) return;
      for (int w = 0; w < NWR; w++) begin
         if (we[w] && wa[w] != ZERO_ADDR) m_mem[wa[w]] = wd[w];
      end
      for (int w = 0; w < NWR; w++) begin
         if (we[w]) m_busy[wa[w]] = 1'b0;
      end
      if (ce && ca != ZERO_ADDR) m_busy[ca] = 1'b1;
   endtask

   task automatic begin_cycle();
      apply();
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
         check($sformatf("rd_data%0d", k), 64'(bus.rd_data[k*DATA_W +: DATA_W]), 64'(exp_rd(ra[k])));
         check($sformatf("rd_busy%0d", k), 64'(bus.rd_busy[k]), 64'(exp_busy(ra[k])));
      end
      check("busy_vec", 64'(bus.busy_vec), 64'(exp_busy_vec()));
   endtask

   task automatic end_cycle();
      $display("cyc %0d rst_n=%b we=%b wa0=%0d wd0=%h wa1=%0d wd1=%h ce=%b ca=%0d ra0=%0d rd0=%h ra1=%0d rd1=%h busy=%h",
               cyc, rst_n, we, wa[0], wd[0], wa[1], wd[1], ce, ca, ra[0], bus.rd_data[31:0],
               ra[1], bus.rd_data[63:32], bus.busy_vec);
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic cycle();
      begin_cycle();
      end_cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      model_clear();
      idle();
      ra[0] = '0;
      ra[1] = '0;
      #1;

      // Writes and a claim while reset is held must have no effect
      we = 2'b11; wa[0] = 5'd3; wd[0] = 32'h1234_5678; wa[1] = 5'd7; wd[1] = 32'h8765_4321;
      ce = 1'b1; ca = 5'd3; ra[0] = 5'd3; ra[1] = 5'd7;
      for (int i = 0; i < 2; i++) begin
         begin_cycle();
         check("rst_rd0", 64'(bus.rd_data[31:0]), 64'h0);
         check("rst_rd1", 64'(bus.rd_data[63:32]), 64'h0);
         check("rst_busy_vec", 64'(bus.busy_vec), 64'h0);
         end_cycle();
      end
      rst_n = 1'b1;
      idle();
      for (int r = 1; r < NREGS; r++) begin
         ra[0] = reg_addr_t'(r);
         ra[1] = reg_addr_t'(NREGS - r);
         begin_cycle();
         check("post_rst_rd0", 64'(bus.rd_data[31:0]), 64'h0);
         end_cycle();
      end

      // Write then read on both ports
      idle();
      we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
      cycle();
      idle();
      ra[0] = 5'd5; ra[1] = 5'd5;
      begin_cycle();
      check("wr_rd0", 64'(bus.rd_data[31:0]), 64'hDEAD_BEEF);
      check("wr_rd1", 64'(bus.rd_data[63:32]), 64'hDEAD_BEEF);
      end_cycle();

      // Same-address write on both ports: port 1 wins for bypass and storage
      we = 2'b11; wa[0] = 5'd7; wd[0] = 32'h1111; wa[1] = 5'd7; wd[1] = 32'h2222;
      ra[0] = 5'd7;
      begin_cycle();
      check("bypass_prio", 64'(bus.rd_data[31:0]), 64'h2222);
      end_cycle();
      idle();
      begin_cycle();
      check("stored_prio", 64'(bus.rd_data[31:0]), 64'h2222);
      end_cycle();

      // Register 0: write and claim both ignored
      we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; ce = 1'b1; ca = 5'd0;
      ra[0] = 5'd0; ra[1] = 5'd0;
      for (int i = 0; i < 2; i++) begin
         begin_cycle();
         check("zero_rd", 64'(bus.rd_data[31:0]), 64'h0);
         check("zero_busy", 64'(bus.busy_vec[0]), 64'h0);
         end_cycle();
         idle();
      end

      // Scoreboard claim / claim+write / plain write on r3
      idle();
      ce = 1'b1; ca = 5'd3; ra[0] = 5'd3; ra[1] = 5'd3;
      cycle();
      idle();
      begin_cycle();
      check("sb_claimed", 64'(bus.rd_busy[0]), 64'h1);
      end_cycle();
      we = 2'b01; wa[0] = 5'd3; wd[0] = 32'h0000_0033; ce = 1'b1; ca = 5'd3;
      begin_cycle();
      check("sb_wr_hides_busy", 64'(bus.rd_busy[0]), 64'h0);
      end_cycle();
      idle();
      begin_cycle();
      check("sb_claim_wins", 64'(bus.busy_vec[3]), 64'h1);
      end_cycle();
      we = 2'b01; wa[0] = 5'd3; wd[0] = 32'h0000_0034;
      cycle();
      idle();
      begin_cycle();
      check("sb_cleared", 64'(bus.busy_vec[3]), 64'h0);
      end_cycle();

      // Asynchronous reset pulse between edges
      we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h0000_00AA;
      cycle();
      idle();
      ce = 1'b1; ca = 5'd9;
      cycle();
      idle();
      ra[0] = 5'd9; ra[1] = 5'd9;
      apply();
      #1;
      check("pre_rst_busy9", 64'(bus.busy_vec[9]), 64'h1);
      check("pre_rst_rd9", 64'(bus.rd_data[31:0]), 64'hAA);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy_vec", 64'(bus.busy_vec), 64'h0);
      check("mid_rst_rd9", 64'(bus.rd_data[31:0]), 64'h0);
      model_clear();
      rst_n = 1'b1;
      #1;
      check("post_pulse_rd9", 64'(bus.rd_data[31:0]), 64'h0);
      @(posedge clk);
      #1;

      // Randomized traffic focused on a few registers to provoke collisions
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < NRD; k++) begin
            ra[k] = ($urandom_range(0, 3) == 0) ? reg_addr_t'($urandom_range(0, NREGS - 1))
                                                : reg_addr_t'($urandom_range(0, 7));
         end
         for (int w = 0; w < NWR; w++) begin
            wa[w] = reg_addr_t'($urandom_range(0, 7));
            wd[w] = $urandom;
         end
         we = NWR'($urandom);
         ce = ($urandom_range(0, 2) == 0);
         ca = reg_addr_t'($urandom_range(0, 7));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
